// File: rtl/ttt_move_ctrl.sv
// rtl/ttt_move_ctrl.sv - tic-tac-toe cursor, mark placement, turn and win/draw control
module ttt_move_ctrl #(
  parameter bit START_PLAYER = 1'b0,
  parameter bit WRAP         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_new,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] cur_row,
  output logic [1:0] cur_col,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       move_ok,
  output logic       move_rej
);

  typedef enum logic [1:0] {ST_PLAY, ST_CHECK, ST_OVER} state_t;

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [8:0] bx_q, bx_d, bo_q, bo_d;
  logic       turn_q, turn_d;
  logic       over_q, over_d;
  logic [1:0] win_q, win_d;
  logic       ok_q, ok_d, rej_q, rej_d;

  logic [3:0] cell_idx;
  logic [8:0] cell_mask;
  logic [8:0] mover_mark;

  // One cursor axis step: dec/inc cancel each other; edges wrap or saturate.
  function automatic logic [1:0] step_axis(input logic [1:0] p, input logic dec, input logic inc);
    logic [1:0] r;
    r = p;
    if (dec && !inc) begin
      if (p == 2'd0) r = WRAP ? 2'd2 : 2'd0;
      else           r = p - 2'd1;
    end else if (inc && !dec) begin
      if (p == 2'd2) r = WRAP ? 2'd0 : 2'd2;
      else           r = p + 2'd1;
    end
    return r;
  endfunction

  // True when the given mark set fully covers any row, column or diagonal.
  function automatic logic has_line(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Next-state and registered-output logic; btn_new overrides everything.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    bx_d       = bx_q;
    bo_d       = bo_q;
    turn_d     = turn_q;
    over_d     = over_q;
    win_d      = win_q;
    ok_d       = 1'b0;
    rej_d      = 1'b0;
    cell_idx   = {1'b0, row_q, 1'b0} + {2'b00, row_q} + {2'b00, col_q};
    cell_mask  = 9'd1 << cell_idx;
    mover_mark = turn_q ? bo_q : bx_q;

    if (btn_new) begin
      state_d = ST_PLAY;
      row_d   = 2'd1;
      col_d   = 2'd1;
      bx_d    = 9'd0;
      bo_d    = 9'd0;
      turn_d  = START_PLAYER;
      over_d  = 1'b0;
      win_d   = 2'b00;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (btn_sel) begin
            if (((bx_q | bo_q) & cell_mask) != 9'd0) begin
              rej_d = 1'b1;
            end else begin
              if (turn_q) bo_d = bo_q | cell_mask;
              else        bx_d = bx_q | cell_mask;
              ok_d    = 1'b1;
              state_d = ST_CHECK;
            end
          end else begin
            row_d = step_axis(row_q, btn_up, btn_down);
            col_d = step_axis(col_q, btn_left, btn_right);
          end
        end
        ST_CHECK: begin
          if (has_line(mover_mark)) begin
            win_d   = turn_q ? 2'b10 : 2'b01;
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else if ((bx_q | bo_q) == 9'h1FF) begin
            win_d   = 2'b11;
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous reset to a fresh game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLAY;
      row_q   <= 2'd1;
      col_q   <= 2'd1;
      bx_q    <= 9'd0;
      bo_q    <= 9'd0;
      turn_q  <= START_PLAYER;
      over_q  <= 1'b0;
      win_q   <= 2'b00;
      ok_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bx_q    <= bx_d;
      bo_q    <= bo_d;
      turn_q  <= turn_d;
      over_q  <= over_d;
      win_q   <= win_d;
      ok_q    <= ok_d;
      rej_q   <= rej_d;
    end
  end

  assign cur_row   = row_q;
  assign cur_col   = col_q;
  assign board_x   = bx_q;
  assign board_o   = bo_q;
  assign turn      = turn_q;
  assign game_over = over_q;
  assign winner    = win_q;
  assign move_ok   = ok_q;
  assign move_rej  = rej_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// tb/tb_ttt_move_ctrl.sv - self-checking bench for ttt_move_ctrl (two parameter sets)
module tb_ttt_move_ctrl;

  localparam logic [5:0] B_NEW = 6'b100000;
  localparam logic [5:0] B_SEL = 6'b010000;
  localparam logic [5:0] B_UP  = 6'b001000;
  localparam logic [5:0] B_DN  = 6'b000100;
  localparam logic [5:0] B_LF  = 6'b000010;
  localparam logic [5:0] B_RT  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_new = 0, btn_sel = 0, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;

  logic [1:0] cur_row[2], cur_col[2], winner[2];
  logic [8:0] board_x[2], board_o[2];
  logic       turn[2], game_over[2], move_ok[2], move_rej[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_move_ctrl #(.START_PLAYER(1'b0), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .btn_new(btn_new), .btn_sel(btn_sel), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .cur_row(cur_row[0]), .cur_col(cur_col[0]), .board_x(board_x[0]), .board_o(board_o[0]),
    .turn(turn[0]), .game_over(game_over[0]), .winner(winner[0]),
    .move_ok(move_ok[0]), .move_rej(move_rej[0]));

  ttt_move_ctrl #(.START_PLAYER(1'b1), .WRAP(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .btn_new(btn_new), .btn_sel(btn_sel), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .cur_row(cur_row[1]), .cur_col(cur_col[1]), .board_x(board_x[1]), .board_o(board_o[1]),
    .turn(turn[1]), .game_over(game_over[1]), .winner(winner[1]),
    .move_ok(move_ok[1]), .move_rej(move_rej[1]));

  // Game model: cell contents 0 empty / 1 X / 2 O, plus a pending-evaluation flag.
  int sp[2] = '{0, 1};
  int wr[2] = '{1, 0};
  int m_row[2], m_col[2], m_turn[2], m_over[2], m_win[2], m_ok[2], m_rej[2], m_pend[2];
  int m_cell[2][9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset(input int k);
    m_row[k] = 1; m_col[k] = 1; m_turn[k] = sp[k];
    m_over[k] = 0; m_win[k] = 0; m_ok[k] = 0; m_rej[k] = 0; m_pend[k] = 0;
    for (int i = 0; i < 9; i++) m_cell[k][i] = 0;
  endtask

  function automatic int won(input int k, input int v);
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++)
      if (m_cell[k][lines[l][0]] == v && m_cell[k][lines[l][1]] == v && m_cell[k][lines[l][2]] == v)
        return 1;
    return 0;
  endfunction

  function automatic int full(input int k);
    for (int i = 0; i < 9; i++) if (m_cell[k][i] == 0) return 0;
    return 1;
  endfunction

  function automatic int move_axis(input int p, input int d, input int w);
    int n = p + d;
    if (n < 0) n = w ? 2 : 0;
    if (n > 2) n = w ? 0 : 2;
    return n;
  endfunction

  task automatic m_step(input int k);
    int c;
    m_ok[k] = 0; m_rej[k] = 0;
    if (btn_new) begin
      m_reset(k);
    end else if (m_pend[k] != 0) begin
      m_pend[k] = 0;
      if (won(k, m_turn[k] + 1) != 0) begin
        m_over[k] = 1; m_win[k] = m_turn[k] + 1;
      end else if (full(k) != 0) begin
        m_over[k] = 1; m_win[k] = 3;
      end else begin
        m_turn[k] = 1 - m_turn[k];
      end
    end else if (m_over[k] == 0) begin
      if (btn_sel) begin
        c = m_row[k] * 3 + m_col[k];
        if (m_cell[k][c] != 0) m_rej[k] = 1;
        else begin
          m_cell[k][c] = m_turn[k] + 1; m_ok[k] = 1; m_pend[k] = 1;
        end
      end else begin
        m_row[k] = move_axis(m_row[k], int'(btn_down) - int'(btn_up), wr[k]);
        m_col[k] = move_axis(m_col[k], int'(btn_right) - int'(btn_left), wr[k]);
      end
    end
  endtask

  function automatic logic [8:0] m_board(input int k, input int v);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) b[i] = (m_cell[k][i] == v);
    return b;
  endfunction

  // Model advances on the same edges the DUT reacts to.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) m_reset(k);
      else     m_step(k);
    end
  end

  // Every falling edge: both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cur_row[%0d]", k),   int'(cur_row[k]),   m_row[k]);
      chk($sformatf("cur_col[%0d]", k),   int'(cur_col[k]),   m_col[k]);
      chk($sformatf("board_x[%0d]", k),   int'(board_x[k]),   int'(m_board(k, 1)));
      chk($sformatf("board_o[%0d]", k),   int'(board_o[k]),   int'(m_board(k, 2)));
      chk($sformatf("turn[%0d]", k),      int'(turn[k]),      m_turn[k]);
      chk($sformatf("game_over[%0d]", k), int'(game_over[k]), m_over[k]);
      chk($sformatf("winner[%0d]", k),    int'(winner[k]),    m_win[k]);
      chk($sformatf("move_ok[%0d]", k),   int'(move_ok[k]),   m_ok[k]);
      chk($sformatf("move_rej[%0d]", k),  int'(move_rej[k]),  m_rej[k]);
      chk($sformatf("disjoint[%0d]", k),  int'(board_x[k] & board_o[k]), 0);
    end
  end

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  // Walk the cursor (never across an edge) to cell c, select, let CHECK finish.
  task automatic place(input int c);
    while (m_row[0] != c / 3) press(m_row[0] < c / 3 ? B_DN : B_UP);
    while (m_col[0] != c % 3) press(m_col[0] < c % 3 ? B_RT : B_LF);
    press(B_SEL);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_row", int'(cur_row[0]), 1);
    chk("rst_col", int'(cur_col[0]), 1);
    chk("rst_bx", int'(board_x[0]), 0);
    chk("rst_turn0", int'(turn[0]), 0);
    chk("rst_turn1", int'(turn[1]), 1);
    chk("rst_win", int'(winner[0]), 0);

    press(B_UP);
    chk("up1_row_wrap", int'(cur_row[0]), 0);
    press(B_UP);
    chk("up2_row_wrap", int'(cur_row[0]), 2);
    chk("up2_row_sat", int'(cur_row[1]), 0);
    repeat (3) press(B_RT);
    chk("rt3_col_sat", int'(cur_col[1]), 2);
    chk("rt3_col_wrap", int'(cur_col[0]), 1);
    press(B_UP | B_DN);
    chk("updown_row", int'(cur_row[0]), 2);
    press(B_UP | B_RT);
    chk("diag_row", int'(cur_row[0]), 1);
    chk("diag_col", int'(cur_col[0]), 2);
    press(B_NEW);
    chk("new_row_nw", int'(cur_row[1]), 1);
    chk("new_col_nw", int'(cur_col[1]), 1);

    @(negedge clk); btn_sel = 1'b1; btn_left = 1'b1;
    @(negedge clk); btn_sel = 1'b0; btn_left = 1'b0;
    chk("place_bx", int'(board_x[0]), 9'h010);
    chk("place_ok", int'(move_ok[0]), 1);
    chk("place_turn_pre", int'(turn[0]), 0);
    chk("place_col_held", int'(cur_col[0]), 1);
    @(negedge clk);
    chk("place_ok_drop", int'(move_ok[0]), 0);
    chk("place_turn_post", int'(turn[0]), 1);
    btn_sel = 1'b1;
    @(negedge clk); btn_sel = 1'b0;
    chk("rej_pulse", int'(move_rej[0]), 1);
    chk("rej_bx", int'(board_x[0]), 9'h010);
    chk("rej_bo", int'(board_o[0]), 0);
    @(negedge clk);
    chk("rej_drop", int'(move_rej[0]), 0);
    chk("rej_turn", int'(turn[0]), 1);

    press(B_NEW);
    place(0); place(1); place(4); place(2); place(8);
    chk("xwin_winner", int'(winner[0]), 1);
    chk("xwin_over", int'(game_over[0]), 1);
    chk("owin_winner_nw", int'(winner[1]), 2);
    press(B_SEL); press(B_LF); press(B_UP);
    chk("over_row", int'(cur_row[0]), 2);
    chk("over_col", int'(cur_col[0]), 2);
    chk("over_bx", int'(board_x[0]), 9'h111);

    press(B_NEW);
    place(0); place(1); place(2); place(4); place(3); place(5); place(7); place(6); place(8);
    chk("draw_winner", int'(winner[0]), 3);
    chk("draw_full", int'(board_x[0] | board_o[0]), 9'h1FF);
    chk("draw_bx", int'(board_x[0]), 9'h18D);
    chk("draw_winner_nw", int'(winner[1]), 3);

    press(B_NEW);
    press(B_SEL);
    @(negedge clk);
    press(B_NEW | B_SEL);
    chk("newsel_bx", int'(board_x[0]), 0);
    chk("newsel_ok", int'(move_ok[0]), 0);
    place(0); place(1); place(4); place(2); place(8);
    press(B_NEW);
    chk("newover_over", int'(game_over[0]), 0);
    chk("newover_win", int'(winner[0]), 0);

    @(negedge clk); btn_sel = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstchk_bx", int'(board_x[0]), 0);
    chk("rstchk_ok", int'(move_ok[0]), 0);
    chk("rstchk_turn", int'(turn[0]), 0);
    @(negedge clk); btn_sel = 1'b0; rst = 1'b0;
    place(4);
    chk("after_rst_bx", int'(board_x[0]), 9'h010);
    chk("after_rst_turn", int'(turn[0]), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
